// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register-file command initiator.
//   RF_DATA_W / RF_ADDR_W / RF_NUM_REGS : default geometry of the 32x32 register file
//   op_e    : command opcodes carried on cmd_op
//   state_e : initiator FSM states
package regfile_ctrl_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_NUM_REGS = 32;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_SWAP  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR     = 3'd1,
        S_RD     = 3'd2,
        S_SWP_RD = 3'd3,
        S_SWP_W1 = 3'd4,
        S_SWP_W2 = 3'd5,
        S_CLR    = 3'd6
    } state_e;

endpackage

// File: rtl/regFile_32x32.sv
// 32 x 32 register file: one synchronous write port, two combinational read ports.
//   clk                 : write clock
//   rst                 : active-high; blocks writes while asserted, contents are not cleared
//   writeEn/writeAdd/Din: write port, commits on the rising edge
//   read1Add/Dout1      : read port 1 (combinational)
//   read2Add/Dout2      : read port 2 (combinational)
module regFile_32x32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        writeEn,
    input  logic [4:0]  writeAdd,
    input  logic [31:0] Din,
    input  logic [4:0]  read1Add,
    input  logic [4:0]  read2Add,
    output logic [31:0] Dout1,
    output logic [31:0] Dout2
);

    logic [31:0] regs [32];

    always_ff @(posedge clk) begin
        if (writeEn && !rst)
            regs[writeAdd] <= Din;
    end

    assign Dout1 = regs[read1Add];
    assign Dout2 = regs[read2Add];

endmodule

// File: rtl/regfile_cmd_initiator.sv
// Command-driven initiator for a register file with one write port and two
// combinational read ports. Executes WRITE / READ / SWAP / CLEAR commands taken
// from a valid/ready channel; READ data is returned on a valid/ready response channel.
//   clk, rst (async, active-low)
//   cmd_valid/cmd_ready, cmd_op, cmd_addr_a, cmd_addr_b, cmd_data : command channel
//   resp_valid/resp_ready, resp_data                               : READ response channel
//   busy                                                           : FSM active or response pending
//   rf_writeEn/rf_writeAdd/rf_Din, rf_read1Add/rf_read2Add         : to register file
//   rf_Dout1/rf_Dout2                                              : from register file
module regfile_cmd_initiator
    import regfile_ctrl_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_REGS = RF_NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr_a,
    input  logic [ADDR_W-1:0] cmd_addr_b,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              busy,
    output logic              rf_writeEn,
    output logic [ADDR_W-1:0] rf_writeAdd,
    output logic [DATA_W-1:0] rf_Din,
    output logic [ADDR_W-1:0] rf_read1Add,
    output logic [ADDR_W-1:0] rf_read2Add,
    input  logic [DATA_W-1:0] rf_Dout1,
    input  logic [DATA_W-1:0] rf_Dout2
);

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(NUM_REGS - 1);

    state_e            state, state_nxt;
    logic [ADDR_W-1:0] a_q, b_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] tmp_a, tmp_b;
    logic [ADDR_W-1:0] clr_cnt;
    logic              cmd_fire;

    // Latched operand addresses drive the read ports directly, so they simply
    // hold their last value outside the read states.
    assign rf_read1Add = a_q;
    assign rf_read2Add = b_q;
    assign cmd_fire    = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            data_q     <= '0;
            tmp_a      <= '0;
            tmp_b      <= '0;
            clr_cnt    <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            state <= state_nxt;
            if (cmd_fire) begin
                a_q    <= cmd_addr_a;
                b_q    <= cmd_addr_b;
                data_q <= cmd_data;
            end
            // Both operands are captured before either write, so a==b
            // rewrites the unchanged value twice.
            if (state == S_SWP_RD) begin
                tmp_a <= rf_Dout1;
                tmp_b <= rf_Dout2;
            end
            if (state == S_CLR)
                clr_cnt <= (clr_cnt == CLR_LAST) ? '0 : clr_cnt + 1'b1;
            if (state == S_RD) begin
                resp_valid <= 1'b1;
                resp_data  <= rf_Dout1;
            end else if (resp_valid && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

    // Next state and register-file write port. The write port is decoded from
    // state alone, so an async reset removes a write in the same instant.
    always_comb begin
        state_nxt   = state;
        rf_writeEn  = 1'b0;
        rf_writeAdd = '0;
        rf_Din      = '0;
        unique case (state)
            S_IDLE: begin
                if (cmd_fire) begin
                    unique case (op_e'(cmd_op))
                        OP_WRITE: state_nxt = S_WR;
                        OP_READ:  state_nxt = S_RD;
                        OP_SWAP:  state_nxt = S_SWP_RD;
                        OP_CLEAR: state_nxt = S_CLR;
                        default:  state_nxt = S_IDLE;
                    endcase
                end
            end
            S_WR: begin
                rf_writeEn  = 1'b1;
                rf_writeAdd = a_q;
                rf_Din      = data_q;
                state_nxt   = S_IDLE;
            end
            S_RD:     state_nxt = S_IDLE;
            S_SWP_RD: state_nxt = S_SWP_W1;
            S_SWP_W1: begin
                rf_writeEn  = 1'b1;
                rf_writeAdd = a_q;
                rf_Din      = tmp_b;
                state_nxt   = S_SWP_W2;
            end
            S_SWP_W2: begin
                rf_writeEn  = 1'b1;
                rf_writeAdd = b_q;
                rf_Din      = tmp_a;
                state_nxt   = S_IDLE;
            end
            S_CLR: begin
                rf_writeEn  = 1'b1;
                rf_writeAdd = clr_cnt;
                rf_Din      = '0;
                if (clr_cnt == CLR_LAST)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // rst is folded in so the channel reads not-ready while reset is held.
    assign cmd_ready = rst && (state == S_IDLE) && !resp_valid;
    assign busy      = (state != S_IDLE) || resp_valid;

endmodule
